// File: rtl/checkers_state_rx.sv
`default_nettype none
// ============================================================================
// checkers_state_rx : UART receiver for the opponent's game-state byte; feeds
// the receiveState PIO. Optional even parity: define CHECKERS_RX_PARITY_EN.
// Revision: 1.0
// ============================================================================
module checkers_state_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial,
    input  logic       clear_valid,
    output logic [7:0] state_out,
    output logic       state_valid,
    output logic       overrun,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
`ifdef CHECKERS_RX_PARITY_EN
        , ST_PARITY = 3'd5
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   good_q, good_d;
    logic [7:0]             state_out_q, state_out_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;
`ifdef CHECKERS_RX_PARITY_EN
    logic                   par_q, par_d;
`endif
    logic                   rxs;
    logic                   frame_ok;

    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef CHECKERS_RX_PARITY_EN
    assign frame_ok = rxs && ((^shift_q) == par_q);
`else
    assign frame_ok = rxs;
`endif

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx_serial};
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        good_d      = 1'b0;
        state_out_d = state_out_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        ferr_d      = ferr_q;
`ifdef CHECKERS_RX_PARITY_EN
        par_d       = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    state_d = rxs ? ST_IDLE : ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef CHECKERS_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef CHECKERS_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    par_d   = rxs;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    if (frame_ok) begin
                        good_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    // A low stop bit means the line may be held in break.
                    state_d = rxs ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_BREAK) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (clear_valid) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        // Byte publish lags the stop sample by one cycle; it overrides a clear.
        if (good_q) begin
            state_out_d = shift_q;
            valid_d     = 1'b1;
            ferr_d      = 1'b0;
            overrun_d   = clear_valid ? 1'b0 : (overrun_q | valid_q);
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'd0;
            good_q      <= 1'b0;
            state_out_q <= 8'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CHECKERS_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            good_q      <= good_d;
            state_out_q <= state_out_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            ferr_q      <= ferr_d;
            busy_q      <= busy_d;
`ifdef CHECKERS_RX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign state_out   = state_out_q;
    assign state_valid = valid_q;
    assign overrun     = overrun_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_checkers_state_rx.sv
`default_nettype none
// tb_checkers_state_rx : directed + randomized frames against a frame-level
// reference model of the state receiver (CLKS_PER_BIT=8, SYNC_STAGES=2).
module tb_checkers_state_rx;

    localparam int CPB = 8;
    localparam int SS  = 2;
`ifdef CHECKERS_RX_PARITY_EN
    localparam int EXP_LAT = SS + (19 * CPB) / 2 + 1 + CPB;
`else
    localparam int EXP_LAT = SS + (19 * CPB) / 2 + 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_serial;
    logic       clear_valid;
    logic [7:0] state_out;
    logic       state_valid;
    logic       overrun;
    logic       frame_error;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the receiver's visible status after each frame/event.
    logic [7:0] m_out;
    logic       m_valid;
    logic       m_ovr;
    logic       m_ferr;

    int lat;
    bit clr_done;

    checkers_state_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_serial  (rx_serial),
        .clear_valid(clear_valid),
        .state_out  (state_out),
        .state_valid(state_valid),
        .overrun    (overrun),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag, input logic exp_busy);
        chk({tag, "/state_out"},   state_out,   m_out);
        chk({tag, "/state_valid"}, {7'd0, state_valid}, {7'd0, m_valid});
        chk({tag, "/overrun"},     {7'd0, overrun},     {7'd0, m_ovr});
        chk({tag, "/frame_error"}, {7'd0, frame_error}, {7'd0, m_ferr});
        chk({tag, "/busy"},        {7'd0, busy},        {7'd0, exp_busy});
    endtask

    task automatic model_good(input logic [7:0] d, input bit clr);
        if (clr)          m_ovr = 1'b0;
        else if (m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_out   = d;
        m_ferr  = 1'b0;
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_reset();
        m_out = 8'd0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_valid = 1'b1;
        @(negedge clk);
        clear_valid = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    // Drives one frame cycle by cycle from a negedge, then `tail` cycles at tail_lvl.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit bad_par,
                              input bit clr_at_upd, input int tail, input bit tail_lvl);
        logic lv[$];
        logic fb[$];
        bit   was_valid;
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(d[i]);
`ifdef CHECKERS_RX_PARITY_EN
        fb.push_back((^d) ^ bad_par);
`else
        if (bad_par) fb.push_back(1'b1);
`endif
        fb.push_back(stop_bit);
        foreach (fb[b]) for (int c = 0; c < CPB; c++) lv.push_back(fb[b]);
        for (int c = 0; c < tail; c++) lv.push_back(tail_lvl);
        lat       = -1;
        clr_done  = 0;
        was_valid = state_valid;
        foreach (lv[i]) begin
            rx_serial   = lv[i];
            clear_valid = 1'b0;
            if (clr_at_upd && !clr_done && i > CPB && busy === 1'b0) begin
                clear_valid = 1'b1;
                clr_done    = 1;
            end
            @(negedge clk);
            if (lat < 0 && !was_valid && state_valid === 1'b1) lat = i + 1;
        end
        clear_valid = 1'b0;
        if (clr_at_upd) chk("clear_window_seen", {7'd0, clr_done}, 8'd1);
    endtask

    initial begin
        logic [7:0] d;
        bit         bad;
        bit         clr;
        int         seen_busy;
        int         back_idle;

        reset_n     = 1'b0;
        rx_serial   = 1'b1;
        clear_valid = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_model("reset", 1'b0);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check_model("idle_after_reset", 1'b0);

        // First byte: also measures start-edge-to-valid latency.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 12, 1'b1);
        model_good(8'hA5, 1'b0);
        check_model("byte_A5", 1'b0);
        n_assert++;
        assert (lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2)
        else begin
            n_fail++;
            $error("FAIL latency_A5: observed %0d cycles expected %0d", lat, EXP_LAT);
        end
        pulse_clear();
        check_model("clear_after_A5", 1'b0);

        // Glitch shorter than half a bit must be rejected.
        seen_busy = 0;
        back_idle = 0;
        rx_serial = 1'b0;
        repeat (2) @(negedge clk);
        rx_serial = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy === 1'b1) seen_busy = 1;
            if (seen_busy == 1 && busy === 1'b0 && back_idle == 0) back_idle = 1;
        end
        chk("glitch_started", 8'(seen_busy), 8'd1);
        chk("glitch_returned_idle", 8'(back_idle), 8'd1);
        check_model("after_glitch", 1'b0);

        // Bad stop bit with line held low -> break.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 22, 1'b0);
        m_ferr = 1'b1;
        check_model("bad_stop_held_low", 1'b1);
        rx_serial = 1'b1;
        repeat (6) @(negedge clk);
        check_model("break_released", 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 12, 1'b1);
        model_good(8'h5A, 1'b0);
        check_model("byte_5A", 1'b0);

        // Overrun, then clear coinciding with the update cycle.
        pulse_clear();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 12, 1'b1);
        model_good(8'h11, 1'b0);
        check_model("byte_11", 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 12, 1'b1);
        model_good(8'h22, 1'b0);
        check_model("byte_22_overrun", 1'b0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b1, 12, 1'b1);
        model_good(8'h33, 1'b1);
        check_model("byte_33_clear_in_update", 1'b0);

        // Randomized frames with random clears and occasional bad stop bits.
        for (int r = 0; r < 8; r++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) pulse_clear();
            if (bad) begin
                send_frame(d, 1'b0, 1'b0, 1'b0, 16, 1'b0);
                rx_serial = 1'b1;
                repeat (8) @(negedge clk);
                m_ferr = 1'b1;
            end else begin
                send_frame(d, 1'b1, 1'b0, clr, 12, 1'b1);
                model_good(d, clr);
            end
            check_model($sformatf("random_%0d", r), 1'b0);
        end

        // Reset in the middle of 0xF0 (start + 4 data bits).
        rx_serial = 1'b0;
        repeat (CPB * 5) @(negedge clk);
        reset_n   = 1'b0;
        rx_serial = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_model("reset_mid_frame", 1'b0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_model("after_mid_reset", 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 12, 1'b1);
        model_good(8'h0F, 1'b0);
        check_model("byte_0F", 1'b0);

`ifdef CHECKERS_RX_PARITY_EN
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0, 12, 1'b1);
        m_ferr = 1'b1;
        check_model("bad_parity_0F", 1'b0);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 12, 1'b1);
        model_good(8'h96, 1'b0);
        check_model("good_parity_96", 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
